// File: rtl/muldiv_pkg.sv
`default_nettype none
// muldiv_pkg -- shared width, op codes and FSM states for the multiply/divide unit.
// Revision 1.0
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_sign.sv
`default_nettype none
// muldiv_sign -- operand magnitudes and final sign fixup / result selection.
// Revision 1.0
module muldiv_sign
   import muldiv_pkg::*;
(
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   input  logic [2*XLEN-1:0] product,
   input  logic [XLEN-1:0]   quotient,
   input  logic [XLEN-1:0]   remainder,
   output logic [XLEN-1:0]   mag_a,
   output logic [XLEN-1:0]   mag_b,
   output logic [XLEN-1:0]   result
);

   logic              a_signed;
   logic              b_signed;
   logic              a_neg;
   logic              b_neg;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix;
   logic [XLEN-1:0]   rem_fix;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (funct3)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU:                 a_signed = 1'b1;
         OP_MULHU, OP_DIVU, OP_REMU: ;
         default: ;
      endcase
   end

   assign a_neg = a_signed & op_a[XLEN-1];
   assign b_neg = b_signed & op_b[XLEN-1];

   assign mag_a = a_neg ? -op_a : op_a;
   assign mag_b = b_neg ? -op_b : op_b;

   // Remainder follows the dividend's sign; quotient and product the XOR of both.
   assign prod_fix = (a_neg ^ b_neg) ? -product  : product;
   assign quot_fix = (a_neg ^ b_neg) ? -quotient : quotient;
   assign rem_fix  = a_neg ? -remainder : remainder;

   always_comb begin
      result = rem_fix;
      case (funct3)
         OP_MUL:                       result = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              result = quot_fix;
         default:                      result = rem_fix;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// muldiv_unit -- iterative RV32M multiply (shift-add) / divide (restoring) unit.
// Revision 1.0
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            reg_write
);
   import muldiv_pkg::*;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        funct3_q;
   logic [XLEN-1:0]   a_q;
   logic [XLEN-1:0]   b_q;
   logic [4:0]        rd_q;
   logic [2*XLEN-1:0] acc;
   logic [5:0]        cnt;

   logic [2:0]        sel_funct3;
   logic [XLEN-1:0]   sel_a;
   logic [XLEN-1:0]   sel_b;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   fixed_result;

   logic              iter_done;
   logic              div_zero;
   logic              div_ovf;
   logic              special;
   logic [XLEN-1:0]   special_result;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_next;

   // In IDLE the sign block sees the incoming operands so the accumulator can be seeded on the accept edge.
   assign sel_funct3 = (state == ST_IDLE) ? funct3   : funct3_q;
   assign sel_a      = (state == ST_IDLE) ? rs1_data : a_q;
   assign sel_b      = (state == ST_IDLE) ? rs2_data : b_q;

   muldiv_sign u_sign (
      .funct3    (sel_funct3),
      .op_a      (sel_a),
      .op_b      (sel_b),
      .product   (acc),
      .quotient  (acc[XLEN-1:0]),
      .remainder (acc[2*XLEN-1:XLEN]),
      .mag_a     (mag_a),
      .mag_b     (mag_b),
      .result    (fixed_result)
   );

   assign iter_done = (cnt == 6'(XLEN));
   assign div_zero  = (b_q == '0);
   assign div_ovf   = !funct3_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
   assign special   = div_zero || div_ovf;

   always_comb begin
      if (div_zero)
         special_result = funct3_q[1] ? a_q : '1;
      else
         special_result = funct3_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // Shift-add: upper half accumulates, lower half shifts the multiplier out.
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   // Restoring step: upper half is the partial remainder, lower half the dividend/quotient.
   assign div_shift = acc[2*XLEN-1:XLEN-1];
   assign div_diff  = div_shift - {1'b0, mag_b};
   assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = funct3[2] ? ST_DIV : ST_MUL;
         ST_MUL:  if (iter_done) state_nxt = ST_DONE;
         ST_DIV:  if (special || iter_done) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != ST_IDLE);
      done = (state == ST_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         funct3_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rd_q      <= '0;
         acc       <= '0;
         cnt       <= '0;
         result    <= '0;
         rd_out    <= '0;
         reg_write <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  funct3_q <= funct3;
                  a_q      <= rs1_data;
                  b_q      <= rs2_data;
                  rd_q     <= rd_in;
                  acc      <= funct3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                  cnt      <= '0;
               end
            end
            ST_MUL, ST_DIV: begin
               if (state_nxt == ST_DONE) begin
                  result    <= (state == ST_DIV && special) ? special_result : fixed_result;
                  rd_out    <= rd_q;
                  reg_write <= (rd_q != 5'd0);
               end else begin
                  acc <= (state == ST_MUL) ? mul_next : div_next;
                  cnt <= cnt + 6'd1;
               end
            end
            default: begin
               result    <= '0;
               rd_out    <= '0;
               reg_write <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: rs1_data  input  32  operand A from the register file read port.
REQ-007 SHALL have port: rs2_data  input  32  operand B from the register file read port.
REQ-008 SHALL have port: rd_in  input  5  destination register index.
REQ-009 SHALL have port: busy  output  1  high from the cycle after start is accepted until done falls.
REQ-010 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: result  output  32  result; valid while done=1, else 0.
REQ-012 SHALL have port: rd_out  output  5  latched rd_in; valid while done=1.
REQ-013 SHALL have port: reg_write  output  1  equals done AND (rd_out != 0); drives the register file write enable.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-015 IDLE with start=1 SHALL latch funct3, rs1_data, rs2_data and rd_in on that edge, then go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-016 start while not IDLE SHALL be ignored; the operation in flight is unaffected and no request is queued.
REQ-017 MUL SHALL run exactly 32 shift-add iterations on operand magnitudes into a 64-bit accumulator, then go to DONE.
REQ-018 Operand signedness SHALL be: MUL/MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
REQ-019 The product sign SHALL be applied at the MUL->DONE transition; MUL returns bits 31:0, and MULH/MULHSU/MULHU return bits 63:32.
REQ-020 DIV SHALL run exactly 32 restoring-division iterations on magnitudes, then go to DONE.
REQ-021 Quotient sign SHALL be sign(A) XOR sign(B); remainder sign SHALL be sign(A); DIVU and REMU use no sign handling.
REQ-022 Divisor=0 SHALL skip iteration and go directly to DONE with: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = A.
REQ-023 Signed overflow (A=0x80000000, B=0xFFFFFFFF) SHALL skip iteration with: DIV result 0x80000000; REM result 0.
REQ-024 Iterative ops SHALL assert done for the cycle beginning at the 33rd rising edge after the accepting edge; special cases SHALL assert it at the 1st.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE; a start in that DONE cycle SHALL be ignored.
REQ-026 result, rd_out and reg_write SHALL be registered and stable for the whole done cycle, so the register file's falling-edge write captures them.
REQ-027 All arithmetic SHALL be modulo 2^32 on results, with no exceptions or flags.

Reset
REQ-028 reset=1 SHALL immediately force IDLE with busy=0, done=0, reg_write=0, result=0, rd_out=0 and all internal registers cleared.
REQ-029 Reset during MUL, DIV or DONE SHALL abort the operation and suppress any write.
REQ-030 The first rising edge after reset deasserts SHALL accept start normally.

Structure
REQ-031 Package muldiv_pkg SHALL hold the XLEN constant, the eight funct3 op codes and the FSM state enum.
REQ-032 Sub-module muldiv_sign (combinational) SHALL compute operand magnitudes and apply the final sign fixup; iteration logic remains in muldiv_unit.

Verification
REQ-033 MUL: A=7, B=0xFFFFFFFD, rd=5 -> done at edge 33, result=0xFFFFFFEB, rd_out=5, reg_write=1.
REQ-034 MULHU: A=B=0xFFFFFFFF -> result=0xFFFFFFFE; MULH with the same operands -> result=0.
REQ-035 DIV/REM: A=0xFFFFFFF9 (-7), B=2 -> DIV result=0xFFFFFFFD; REM result=0xFFFFFFFF.
REQ-036 Special cases: DIVU 5/0 -> done at edge 1, result=0xFFFFFFFF; REM 0x80000000 % 0xFFFFFFFF -> done at edge 1, result=0.
REQ-037 Control: rd=0 -> done pulses, reg_write stays 0; start held high during busy -> exactly one done; reset at iteration 10 -> outputs zero, no done, next start completes correctly.
